// File: rtl/axis_depacketizer_if.sv
// AXI4-Stream bundle shared by the DMA-side and DAC-side ports of axis_depacketizer.
// Latency: none, it only groups wires.
// Backpressure: plain tvalid/tready handshake, the master drives tvalid/tdata/tlast.
interface axis_depacketizer_if #(
  parameter int TDATA_WIDTH = 64
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_depacketizer.sv
// Strips tlast framing from PKT_LENGTH-beat DMA packets into a plain sample stream, checks framing, runs pkt_count packets per trigger.
// Latency: 1 cycle from accepted input beat to output register; full throughput with simultaneous push/pop.
// Backpressure: s_axis.tready follows the single output register in RUN; AXIS_DEPACKETIZER_HOLD_EN keeps m_axis.tvalid high for the whole run.
module axis_depacketizer #(
  parameter int TDATA_WIDTH = 64,
  parameter int PKT_LENGTH  = 32768
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                trig,
  input  logic [31:0]         pkt_count,
  axis_depacketizer_if.slave  s_axis,
  axis_depacketizer_if.master m_axis,
  output logic                busy,
  output logic                done,
  output logic [31:0]         pkt_done,
  output logic                err_early_last,
  output logic                err_missing_last,
  output logic                underrun
);

  localparam int BW = $clog2(PKT_LENGTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESYNC, DRAIN} state_t;

  state_t                 state;
  logic                   trig_d;
  logic [31:0]            cnt_q;
  logic [BW-1:0]          beat_cnt;
  logic                   out_v;
  logic [TDATA_WIDTH-1:0] out_d;
  logic                   first_cyc;

  logic        s_rdy;
  logic        accept;
  logic        pop;
  logic        at_last;
  logic [31:0] pkt_next;
  logic        final_pkt;

  // Input is open while the output register can take a beat (RUN) or while discarding (RESYNC).
  always_comb begin
    s_rdy = 1'b0;
    if (state == RUN)
      s_rdy = ~out_v | m_axis.tready;
    else if (state == RESYNC)
      s_rdy = 1'b1;
  end

  assign s_axis.tready = s_rdy;
  assign accept        = s_axis.tvalid & s_rdy;
  assign pop           = m_axis.tready & out_v;
  assign at_last       = (beat_cnt == LAST_BEAT);
  assign pkt_next      = pkt_done + 32'd1;
  assign final_pkt     = (pkt_next == cnt_q);

`ifdef AXIS_DEPACKETIZER_HOLD_EN
  // Continuous DAC mode: out_d is never cleared on pop, so starved cycles repeat the last sample.
  assign m_axis.tvalid = busy;
`else
  assign m_axis.tvalid = out_v;
`endif
  assign m_axis.tdata = out_d;
  assign m_axis.tlast = 1'b0;

  // Run control, framing checks, status and the output register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state            <= IDLE;
      trig_d           <= 1'b0;
      cnt_q            <= '0;
      beat_cnt         <= '0;
      out_v            <= 1'b0;
      out_d            <= '0;
      first_cyc        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pkt_done         <= '0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
      underrun         <= 1'b0;
    end else begin
      trig_d    <= trig;
      done      <= 1'b0;
      first_cyc <= 1'b0;
      // A load in RUN below overrides this, giving one beat per cycle on push+pop.
      if (pop)
        out_v <= 1'b0;

      case (state)
        IDLE: begin
          if (trig & ~trig_d) begin
            cnt_q            <= pkt_count;
            pkt_done         <= '0;
            beat_cnt         <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            underrun         <= 1'b0;
            out_d            <= '0;
            if (pkt_count == 32'd0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              first_cyc <= 1'b1;
            end
          end
        end

        RUN: begin
          if (m_axis.tready & ~out_v & ~s_axis.tvalid & ~first_cyc)
            underrun <= 1'b1;
          if (accept) begin
            out_v <= 1'b1;
            out_d <= s_axis.tdata;
            if (s_axis.tlast) begin
              if (!at_last)
                err_early_last <= 1'b1;
              beat_cnt <= '0;
              pkt_done <= pkt_next;
              if (final_pkt)
                state <= DRAIN;
            end else if (at_last) begin
              // Final beat is still a valid sample; the overrun beats after it are dropped.
              err_missing_last <= 1'b1;
              beat_cnt         <= '0;
              state            <= RESYNC;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        RESYNC: begin
          if (accept & s_axis.tlast) begin
            beat_cnt <= '0;
            pkt_done <= pkt_next;
            state    <= final_pkt ? DRAIN : RUN;
          end
        end

        DRAIN: begin
          if (~out_v | pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_depacketizer.sv
// Directed and randomized bench for axis_depacketizer with PKT_LENGTH=8.
// Latency: expected output stream derived per packet from its length alone.
// Backpressure: optional random gaps on s_axis and random m_axis.tready.
module tb_axis_depacketizer;
  localparam int W = 64;
  localparam int L = 8;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        trig;
  logic [31:0] pkt_count;
  logic        busy, done, err_early_last, err_missing_last, underrun;
  logic [31:0] pkt_done;

  axis_depacketizer_if #(.TDATA_WIDTH(W)) s_if ();
  axis_depacketizer_if #(.TDATA_WIDTH(W)) m_if ();

  axis_depacketizer #(.TDATA_WIDTH(W), .PKT_LENGTH(L)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .trig             (trig),
    .pkt_count        (pkt_count),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .busy             (busy),
    .done             (done),
    .pkt_done         (pkt_done),
    .err_early_last   (err_early_last),
    .err_missing_last (err_missing_last),
    .underrun         (underrun)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;
  bit m_rand = 1'b0;

  logic [W-1:0] bd[$];
  bit           bl[$];
  logic [W-1:0] exp_q[$];
  int           e_pk;
  bit           e_early, e_miss;

  logic [W-1:0] got[$];
  int           done_cnt = 0;
  int           busy_cnt = 0;
  int           starve_cnt = 0;
  bit           have_last = 1'b0;
  logic [W-1:0] last_v = '0;

  // Sink-side ready: always 1, or a coin toss per cycle.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_if.tready = m_rand ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Output capture and event counters, sampled mid-cycle.
  always @(negedge aclk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (busy && m_if.tready && !s_if.tvalid) starve_cnt++;
    if (trig && !busy) begin
      have_last = 1'b0;
    end else if (m_if.tvalid && m_if.tready) begin
`ifdef AXIS_DEPACKETIZER_HOLD_EN
      if (!have_last || m_if.tdata != last_v) got.push_back(m_if.tdata);
`else
      got.push_back(m_if.tdata);
`endif
      last_v    = m_if.tdata;
      have_last = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_run();
    bd.delete();
    bl.delete();
  endtask

  // Packet of n beats, tlast on its final beat; data is the beat index within the run.
  task automatic add_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      bd.push_back(W'(bd.size()));
      bl.push_back(i == n - 1);
    end
  endtask

  // Reference: split the input at tlast; short packets pass whole (early error),
  // long packets pass their first L beats (missing-last error), stop after cnt packets.
  task automatic model(input int cnt);
    int s;
    exp_q.delete();
    e_pk = 0; e_early = 0; e_miss = 0; s = 0;
    for (int i = 0; i < bd.size() && e_pk < cnt; i++) begin
      if (bl[i]) begin
        int n;
        n = i - s + 1;
        for (int k = 0; k < n && k < L; k++) exp_q.push_back(bd[s + k]);
        if (n < L) e_early = 1;
        if (n > L) e_miss = 1;
        e_pk++;
        s = i + 1;
      end
    end
  endtask

  task automatic do_trig(input int cnt);
    pkt_count = 32'(cnt);
    trig = 1'b1;
    @(posedge aclk);
    #1;
    trig = 1'b0;
  endtask

  task automatic drive(input int lo, input int hi, input bit rnd, input int mid);
    for (int i = lo; i < hi; i++) begin
      int to;
      if (rnd) begin
        while ($urandom % 2 == 1) begin
          s_if.tvalid = 1'b0;
          @(posedge aclk);
          #1;
        end
      end
      if (i == mid) begin
        trig = 1'b1;
        pkt_count = 32'd5;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = bd[i];
      s_if.tlast  = bl[i];
      to = 0;
      @(negedge aclk);
      while (!s_if.tready && to < 200) begin
        @(negedge aclk);
        to++;
      end
      if (to >= 200) begin
        chk("accept timeout", 64'(s_if.tready), 64'd1);
        break;
      end
      @(posedge aclk);
      #1;
      trig = 1'b0;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int to;
    to = 0;
    @(negedge aclk);
    while (busy && to < 300) begin
      @(negedge aclk);
      to++;
    end
    chk({tag, " idle"}, 64'(busy), 64'd0);
    repeat (2) @(negedge aclk);
    @(posedge aclk);
    #1;
  endtask

  task automatic finish_run(input string tag, input int s0, input int d0, input int cnt);
    model(cnt);
    chk({tag, " out count"}, 64'(got.size() - s0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && s0 + i < got.size(); i++)
      chk({tag, " out data"}, got[s0 + i], exp_q[i]);
    chk({tag, " pkt_done"}, 64'(pkt_done), 64'(e_pk));
    chk({tag, " err_early_last"}, 64'(err_early_last), 64'(e_early));
    chk({tag, " err_missing_last"}, 64'(err_missing_last), 64'(e_miss));
    chk({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int s0, d0, b0, st0;
    aresetn = 1'b0; trig = 1'b0; pkt_count = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset pkt_done", 64'(pkt_done), 64'd0);
    chk("reset m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("reset m_tdata", m_if.tdata, 64'd0);
    chk("reset s_tready", 64'(s_if.tready), 64'd0);
    chk("reset flags", {61'd0, err_early_last, err_missing_last, underrun}, 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // T1: three good packets, continuous flow.
    new_run(); repeat (3) add_pkt(8);
    s0 = got.size(); d0 = done_cnt;
    do_trig(3);
    drive(0, bd.size(), 1'b0, -1);
    @(negedge aclk);
    chk("T1 s_tready after last", 64'(s_if.tready), 64'd0);
    wait_idle("T1");
    finish_run("T1", s0, d0, 3);
    chk("T1 underrun", 64'(underrun), 64'd0);

    // T2: early tlast on the 5th beat, then a good packet.
    new_run(); add_pkt(5); add_pkt(8);
    s0 = got.size(); d0 = done_cnt;
    do_trig(2);
    drive(0, bd.size(), 1'b0, -1);
    wait_idle("T2");
    finish_run("T2", s0, d0, 2);

    // T3: 11-beat packet (missing tlast at beat 7), then a good packet.
    new_run(); add_pkt(11); add_pkt(8);
    s0 = got.size(); d0 = done_cnt;
    do_trig(2);
    drive(0, bd.size(), 1'b0, -1);
    wait_idle("T3");
    finish_run("T3", s0, d0, 2);

    // T4: random valid/ready over mixed packets.
    m_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      new_run(); add_pkt(8); add_pkt(3 + r); add_pkt(8); add_pkt(10 + r); add_pkt(8);
      s0 = got.size(); d0 = done_cnt; st0 = starve_cnt;
      do_trig(5);
      drive(0, bd.size(), 1'b1, -1);
      wait_idle("T4");
      finish_run("T4", s0, d0, 5);
      chk("T4 underrun without starvation", 64'(underrun && (starve_cnt == st0)), 64'd0);
    end
    m_rand = 1'b0;

    // T5a: zero-packet run.
    d0 = done_cnt; b0 = busy_cnt;
    do_trig(0);
    repeat (4) @(negedge aclk);
    chk("T5 zero done pulses", 64'(done_cnt - d0), 64'd1);
    chk("T5 zero busy cycles", 64'(busy_cnt - b0), 64'd0);
    chk("T5 zero pkt_done", 64'(pkt_done), 64'd0);
    @(posedge aclk);
    #1;

    // T5b: a second trigger edge during RUN is ignored.
    new_run(); add_pkt(8);
    s0 = got.size(); d0 = done_cnt;
    do_trig(1);
    drive(0, bd.size(), 1'b0, 3);
    wait_idle("T5b");
    finish_run("T5b", s0, d0, 1);

    // T6: reset mid-packet, then a clean run with a starved gap.
    new_run(); add_pkt(8); add_pkt(8);
    do_trig(2);
    drive(0, 3, 1'b0, -1);
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("T6 reset busy", 64'(busy), 64'd0);
    chk("T6 reset pkt_done", 64'(pkt_done), 64'd0);
    chk("T6 reset m_tvalid", 64'(m_if.tvalid), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    new_run(); add_pkt(8);
    s0 = got.size(); d0 = done_cnt;
    do_trig(1);
    drive(0, 4, 1'b0, -1);
    @(negedge aclk);
    chk("T6 held beat", m_if.tdata, 64'd3);
    @(posedge aclk);
    #1;
    @(negedge aclk);
`ifdef AXIS_DEPACKETIZER_HOLD_EN
    chk("T6 starved m_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("T6 starved repeat", m_if.tdata, 64'd3);
`else
    chk("T6 starved m_tvalid", 64'(m_if.tvalid), 64'd0);
`endif
    @(posedge aclk);
    #1;
    drive(4, 8, 1'b0, -1);
    wait_idle("T6");
    finish_run("T6", s0, d0, 1);
    chk("T6 underrun", 64'(underrun), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
